// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Single-cycle arithmetic, logic and shift ops complete
// one cycle after the start edge. MUL (shift-add) and DIV (restoring) iterate
// one bit per cycle and complete P_WIDTH+1 cycles after the start edge.
// The divider is built only when ALU_MC_DIV_EN is defined; otherwise DIV behaves
// like an unused opcode and O_REM is always 0.
module alu_mc #(
  parameter int P_WIDTH = 16
) (
  input  logic               I_CLK,
  input  logic               I_RESET,
  input  logic               I_START,
  input  logic [3:0]         I_OPCODE,
  input  logic [P_WIDTH-1:0] I_A,
  input  logic [P_WIDTH-1:0] I_B,
  output logic               O_BUSY,
  output logic               O_DONE,
  output logic [P_WIDTH-1:0] O_C,
  output logic [P_WIDTH-1:0] O_REM,
  output logic [4:0]         O_STATUS
);

  localparam int SHW = $clog2(P_WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_LSH  = 4'd8;
  localparam logic [3:0] OP_RSH  = 4'd9;
  localparam logic [3:0] OP_ALSH = 4'd10;
  localparam logic [3:0] OP_ARSH = 4'd11;
`ifdef ALU_MC_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'd12;
`endif

  typedef enum logic [1:0] {
    IDLE,
`ifdef ALU_MC_DIV_EN
    DIV_RUN,
`endif
    MUL_RUN
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SHW-1:0]     count;
  logic               last_iter;
  logic               start_multi;
  logic [P_WIDTH-1:0] op_a;
  logic [P_WIDTH-1:0] op_b;
  logic [P_WIDTH-1:0] acc;
  logic [P_WIDTH-1:0] mul_acc_next;
  logic [SHW-1:0]     shamt;
  logic [P_WIDTH:0]   sum;
  logic [P_WIDTH-1:0] alu_c;
  logic [4:0]         alu_status;
  logic               carry;
  logic               low;
  logic               flag;
  logic               neg;
  logic               zero_en;

  assign shamt     = I_A[SHW-1:0];
  assign last_iter = (count == SHW'(P_WIDTH - 1));
  assign O_BUSY    = (state != IDLE);

`ifdef ALU_MC_DIV_EN
  assign start_multi = (I_OPCODE == OP_MUL) || (I_OPCODE == OP_DIV);
`else
  assign start_multi = (I_OPCODE == OP_MUL);
`endif

  // Multiplier step: add the shifted multiplicand when the current multiplier bit is set
  assign mul_acc_next = op_b[0] ? (acc + op_a) : acc;

`ifdef ALU_MC_DIV_EN
  logic [P_WIDTH:0]   div_shift;
  logic [P_WIDTH:0]   div_trial;
  logic               div_ok;
  logic [P_WIDTH-1:0] rem_next;
  logic [P_WIDTH-1:0] quo_next;

  // Restoring divider step: bring down the next dividend bit and try subtracting the divisor
  assign div_shift = {acc, op_b[P_WIDTH-1]};
  assign div_trial = div_shift - {1'b0, op_a};
  assign div_ok    = ~div_trial[P_WIDTH];
  assign rem_next  = div_ok ? div_trial[P_WIDTH-1:0] : div_shift[P_WIDTH-1:0];
  assign quo_next  = {op_b[P_WIDTH-2:0], div_ok};
`endif

  // Single-cycle result and flags, computed as I_B op I_A
  always_comb begin
    alu_c   = '0;
    sum     = '0;
    carry   = 1'b0;
    low     = 1'b0;
    flag    = 1'b0;
    neg     = 1'b0;
    zero_en = 1'b1;
    case (I_OPCODE)
      OP_ADD, OP_ADDC: begin
        sum   = {1'b0, I_B} + {1'b0, I_A} + {{P_WIDTH{1'b0}}, (I_OPCODE == OP_ADDC)};
        alu_c = sum[P_WIDTH-1:0];
        carry = sum[P_WIDTH];
        low   = (I_B > I_A);
        flag  = (I_A[P_WIDTH-1] == I_B[P_WIDTH-1]) && (alu_c[P_WIDTH-1] != I_A[P_WIDTH-1]);
        neg   = ((I_A[P_WIDTH-1] ^ I_B[P_WIDTH-1]) & alu_c[P_WIDTH-1]) |
                (I_A[P_WIDTH-1] & I_B[P_WIDTH-1]);
      end
      OP_SUB: begin
        alu_c = I_B - I_A;
        carry = (I_B > I_A);
        low   = (I_B > I_A);
        flag  = (I_A[P_WIDTH-1] != I_B[P_WIDTH-1]) && (alu_c[P_WIDTH-1] != I_B[P_WIDTH-1]);
        neg   = ($signed(I_B) > $signed(I_A));
      end
      OP_NOT:  alu_c = ~I_A;
      OP_AND:  alu_c = I_B & I_A;
      OP_OR:   alu_c = I_B | I_A;
      OP_XOR:  alu_c = I_B ^ I_A;
      OP_LSH:  alu_c = I_B << shamt;
      OP_ALSH: alu_c = I_B << shamt;
      OP_RSH:  alu_c = I_B >> shamt;
      OP_ARSH: alu_c = $signed(I_B) >>> shamt;
      default: zero_en = 1'b0;
    endcase
    alu_status = {neg, zero_en && (alu_c == '0), flag, low, carry};
  end

  // State register
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic: leave IDLE only for iterative ops, return after the last iteration
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (I_START && (I_OPCODE == OP_MUL)) state_next = MUL_RUN;
`ifdef ALU_MC_DIV_EN
        if (I_START && (I_OPCODE == OP_DIV)) state_next = DIV_RUN;
`endif
      end
      MUL_RUN: if (last_iter) state_next = IDLE;
`ifdef ALU_MC_DIV_EN
      DIV_RUN: if (last_iter) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands at start, iterate while busy, publish results only on completion
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      count    <= '0;
      O_DONE   <= 1'b0;
      O_C      <= '0;
      O_REM    <= '0;
      O_STATUS <= '0;
    end else begin
      O_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (I_START) begin
            if (start_multi) begin
              op_a  <= I_A;
              op_b  <= I_B;
              acc   <= '0;
              count <= '0;
            end else begin
              O_C      <= alu_c;
              O_REM    <= '0;
              O_STATUS <= alu_status;
              O_DONE   <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          acc   <= mul_acc_next;
          op_a  <= op_a << 1;
          op_b  <= op_b >> 1;
          count <= count + SHW'(1);
          if (last_iter) begin
            count    <= '0;
            O_C      <= mul_acc_next;
            O_REM    <= '0;
            O_STATUS <= '0;
            O_DONE   <= 1'b1;
          end
        end
`ifdef ALU_MC_DIV_EN
        DIV_RUN: begin
          acc   <= rem_next;
          op_b  <= quo_next;
          count <= count + SHW'(1);
          if (last_iter) begin
            count    <= '0;
            O_C      <= quo_next;
            O_REM    <= rem_next;
            O_STATUS <= {1'b0, (quo_next == '0), (op_a == '0), 2'b00};
            O_DONE   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The module SHALL have parameter P_WIDTH, default 16, meaning the width of the operands, result and remainder (legal values 8..64).
REQ-002 The module SHALL have port I_CLK, input, 1, the sole clock; all state changes on its rising edge.
REQ-003 The module SHALL have port I_RESET, input, 1, with reset asynchronous and active-high.
REQ-004 The module SHALL have port I_START, input, 1, a request strobe, sampled only while O_BUSY=0.
REQ-005 The module SHALL have port I_OPCODE, input, 4, with codes ADD=0, ADDC=1, MUL=2, SUB=3, NOT=4, AND=5, OR=6, XOR=7, LSH=8, RSH=9, ALSH=10, ARSH=11, DIV=12.
REQ-006 The module SHALL have ports I_A and I_B, input, P_WIDTH each, the operands; the result is I_B op I_A, as in the existing ALU.
REQ-007 The module SHALL have port O_BUSY, output, 1, high while a multi-cycle operation is in progress.
REQ-008 The module SHALL have port O_DONE, output, 1, a one-cycle pulse marking O_C, O_REM and O_STATUS valid.
REQ-009 The module SHALL have port O_C, output, P_WIDTH, the registered result.
REQ-010 The module SHALL have port O_REM, output, P_WIDTH, the DIV remainder, and SHALL drive 0 for all other opcodes.
REQ-011 The module SHALL have port O_STATUS, output, 5, with bit 0 CARRY, bit 1 LOW, bit 2 FLAG, bit 3 ZERO and bit 4 NEGATIVE.

Function
REQ-012 The module SHALL implement states IDLE, MUL_RUN and DIV_RUN, with O_BUSY=1 exactly in MUL_RUN and DIV_RUN.
REQ-013 In IDLE, I_START=1 with any opcode other than MUL or DIV SHALL register the result and flags at that edge, then pulse O_DONE in the following cycle (latency 1); the state stays IDLE, so back-to-back starts give one result per cycle.
REQ-014 Single-cycle ops SHALL follow the CR16 ALU semantics, with all widths generalised to P_WIDTH:
- ADD/ADDC: CARRY is the carry out of MSB; ADDC adds +1.
- ADD/ADDC: LOW is I_B>I_A unsigned.
- ADD/ADDC: FLAG is signed overflow.
- ADD/ADDC: NEGATIVE is operands of mixed sign with result MSB set, or both operands negative.
- SUB: CARRY=LOW=(I_B>I_A unsigned).
- SUB: FLAG is signed overflow.
- SUB: NEGATIVE is I_B>I_A signed.
- Logic and shift ops: only ZERO is meaningful; other flags 0.
- Shift amount: I_A[$clog2(P_WIDTH)-1:0].
- ZERO=(O_C==0) for every op except MUL.
REQ-015 An unused opcode (13-15, or DIV when compiled out) SHALL be handled as a single-cycle op giving O_C=0, O_STATUS=0 and O_DONE pulsed.
REQ-016 MUL SHALL be an iterative shift-add with one operand bit per cycle; I_START in IDLE latches the operands and enters MUL_RUN for P_WIDTH cycles.
REQ-017 MUL SHALL then return to IDLE, pulsing O_DONE in that cycle, for a latency of P_WIDTH+1 cycles from the start edge.
REQ-018 MUL SHALL produce O_C equal to the low P_WIDTH bits of the signed product, with O_STATUS=0.
REQ-019 DIV SHALL be an unsigned restoring divider with one quotient bit per cycle and the same P_WIDTH+1 latency as MUL.
REQ-020 DIV SHALL produce O_C = I_B / I_A and O_REM = I_B % I_A, with ZERO=(O_C==0) and all other flags 0.
REQ-021 DIV with I_A=0 SHALL produce O_C all-ones, O_REM=I_B and FLAG=1, with the same latency as a normal divide.
REQ-022 I_START while O_BUSY=1 SHALL be ignored without error.
REQ-023 Operand changes during MUL_RUN or DIV_RUN SHALL not affect the result, because operands are latched at start.
REQ-024 O_C, O_REM and O_STATUS SHALL hold their last values until the next completion; intermediate iteration values SHALL never appear on them.

Reset
REQ-025 I_RESET=1 SHALL immediately force the state to IDLE and set O_BUSY=0, O_DONE=0, O_C=0, O_REM=0, O_STATUS=0, clearing all iteration counters and operand registers.
REQ-026 A reset asserted mid-operation SHALL abort the operation with no O_DONE.
REQ-027 The first I_START after reset release SHALL be accepted normally.

Configuration
REQ-028 The macro ALU_MC_DIV_EN SHALL control the divider: when defined, DIV_RUN, the divider datapath and the O_REM computation are present.
REQ-029 When ALU_MC_DIV_EN is undefined, DIV SHALL be treated as an unused opcode per REQ-015, DIV_RUN SHALL be absent, and O_REM SHALL be tied to 0.

Verification
REQ-030 A bench SHALL cover these directed scenarios at P_WIDTH=16:
- ADD: A=0x0001, B=0xFFFF -> next cycle O_DONE=1, O_C=0x0000, CARRY=1, ZERO=1, LOW=1.
- MUL: A=0xFFFD (-3), B=0x0007 -> O_BUSY high for 16 cycles, O_DONE at cycle 17, O_C=0xFFEB, O_STATUS=0; an I_START at cycle 5 is ignored.
- DIV: A=0x0007, B=0x0064 -> cycle 17 O_C=0x000E, O_REM=0x0002; divide by zero with A=0, B=0x1234 -> O_C=0xFFFF, O_REM=0x1234, FLAG=1.
- Reset at cycle 8 of a MUL -> all outputs 0 immediately, no O_DONE; a following SUB with A=5, B=3 -> O_C=0xFFFE, CARRY=0, NEGATIVE=0.
- Back-to-back XOR, then LSH (A=4, B=0x0F0F), then opcode 14 on consecutive cycles -> three consecutive O_DONE pulses with O_C=A^B, then 0xF0F0, then 0 with O_STATUS=0.
- With ALU_MC_DIV_EN undefined, DIV -> single-cycle O_DONE, O_C=0, O_STATUS=0.
